// File: rtl/debug_frame_tx.sv
// ---------------------------------------------------------------------------
// debug_frame_tx
//   Debug reporting stage that sits after the accumulator in the BIP datapath.
//   On a rising edge of the processor halt level it snapshots the
//   accumulator, the program counter and the executed-cycle count. It then
//   sends that snapshot to a UART transmitter as an 8-byte frame, one byte
//   at a time, using a start/done handshake for each byte.
//
//   Frame layout (idx 0..7):
//     HEADER, PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], CNT[15:8], CNT[7:0], CHK
//     CHK is the XOR of idx 1..6. The header is not included in CHK.
//
// Ports
//   i_clock     system clock; all state changes on its rising edge
//   i_reset     asynchronous, active-high reset
//   i_halt      halt level from the control unit; its rising edge starts a frame
//   i_acc       accumulator value (E_BITS wide)
//   i_pc        program counter (PC_BITS wide), zero-extended to 16 bits in the frame
//   i_cycles    executed-cycle count (CNT_BITS wide)
//   i_tx_done   1-cycle pulse from the UART TX: the current byte has finished
//   o_tx_data   byte to transmit; held stable from start until done
//   o_tx_start  1-cycle pulse: the UART TX latches o_tx_data
//   o_busy      high while a frame is being sent
//   o_done      1-cycle pulse after the last byte has completed
// ---------------------------------------------------------------------------
module debug_frame_tx #(
    parameter int          E_BITS   = 16,
    parameter int          PC_BITS  = 11,
    parameter int          CNT_BITS = 16,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_halt,
    input  logic [E_BITS-1:0]   i_acc,
    input  logic [PC_BITS-1:0]  i_pc,
    input  logic [CNT_BITS-1:0] i_cycles,
    input  logic                i_tx_done,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    output logic                o_busy,
    output logic                o_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q,   idx_d;
    logic [15:0] acc_q,   acc_d;
    logic [15:0] pc_q,    pc_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        halt_q;

    logic        trig;
    logic [7:0]  frame_bytes [8];

    // A frame starts only on a rising edge of the halt level. Holding halt
    // high does not start a second frame.
    assign trig = i_halt & ~halt_q;

    // Frame contents are built from the snapshot registers only. Input
    // changes after the trigger therefore cannot change a frame in flight.
    always_comb begin
        frame_bytes[0] = HEADER;
        frame_bytes[1] = pc_q[15:8];
        frame_bytes[2] = pc_q[7:0];
        frame_bytes[3] = acc_q[15:8];
        frame_bytes[4] = acc_q[7:0];
        frame_bytes[5] = cnt_q[15:8];
        frame_bytes[6] = cnt_q[7:0];
        frame_bytes[7] = pc_q[15:8] ^ pc_q[7:0] ^ acc_q[15:8] ^ acc_q[7:0]
                       ^ cnt_q[15:8] ^ cnt_q[7:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    acc_d   = 16'(i_acc);
                    pc_d    = 16'(i_pc);
                    cnt_d   = 16'(i_cycles);
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // i_tx_done has an effect only in this state. Pulses that
                // arrive in any other state are ignored.
                if (i_tx_done) begin
                    if (idx_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            acc_q   <= 16'd0;
            pc_q    <= 16'd0;
            cnt_q   <= 16'd0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            halt_q  <= i_halt;
        end
    end

    // All outputs are decoded from the registered state. Because the state
    // register resets asynchronously, the outputs drop to zero as soon as
    // reset is asserted.
    assign o_tx_start = (state_q == ST_SEND);
    assign o_busy     = (state_q == ST_SEND) || (state_q == ST_WAIT);
    assign o_done     = (state_q == ST_DONE);
    assign o_tx_data  = o_busy ? frame_bytes[idx_q] : 8'h00;

endmodule

// File: tb/tb_debug_frame_tx.sv
module tb_debug_frame_tx;

    logic        clk;
    logic        i_reset;
    logic        i_halt;
    logic [15:0] i_acc;
    logic [10:0] i_pc;
    logic [15:0] i_cycles;
    logic        i_tx_done;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;

    int checks;
    int errors;
    int start_cnt;
    int done_cnt;

    debug_frame_tx dut (
        .i_clock   (clk),
        .i_reset   (i_reset),
        .i_halt    (i_halt),
        .i_acc     (i_acc),
        .i_pc      (i_pc),
        .i_cycles  (i_cycles),
        .i_tx_done (i_tx_done),
        .o_tx_data (o_tx_data),
        .o_tx_start(o_tx_start),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start and done pulses independently of the stimulus thread.
    initial begin
        start_cnt = 0;
        done_cnt  = 0;
    end
    always @(negedge clk) begin
        if (o_tx_start === 1'b1) start_cnt++;
        if (o_done === 1'b1)     done_cnt++;
    end

    typedef struct {
        logic [15:0] acc;
        logic [10:0] pc;
        logic [15:0] cyc;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference frame: build the list of bytes with plain integer arithmetic,
    // then fold it into a 64-bit value (byte 0 in the top byte).
    function automatic logic [63:0] ref_frame(input logic [15:0] acc,
                                              input logic [10:0] pc,
                                              input logic [15:0] cyc);
        int unsigned a, p, c, chk;
        int unsigned b [8];
        logic [63:0] r;
        a = acc; p = pc; c = cyc;
        b[0] = 165;
        b[1] = (p / 256) % 256;  b[2] = p % 256;
        b[3] = (a / 256) % 256;  b[4] = a % 256;
        b[5] = (c / 256) % 256;  b[6] = c % 256;
        chk = 0;
        for (int i = 1; i <= 6; i++) chk = chk ^ b[i];
        b[7] = chk;
        r = '0;
        for (int i = 0; i < 8; i++) r = (r << 8) | 64'(b[i] & 32'hFF);
        return r;
    endfunction

    // Make sure halt_q is low, then raise i_halt. Return at the negedge of
    // the cycle in which o_tx_start is expected.
    task automatic raise_halt();
        i_halt = 1'b0;
        @(negedge clk);
        i_halt = 1'b1;
        @(negedge clk);
    endtask

    // UART TX model: for each byte, capture it at start, wait `gap` WAIT
    // cycles, then pulse done. Optional hooks inject a stray done pulse in
    // SEND, change the inputs in the middle of the frame, or stop in WAIT
    // at byte abort_at.
    task automatic serve_frame(input int gap, input bit stray_send, input bit mutate,
                               input int abort_at, output logic [63:0] got);
        logic [7:0] cur;
        got = '0;
        for (int b = 0; b < 8; b++) begin
            check("start_latency", 64'(o_tx_start), 64'd1);
            if (o_tx_start !== 1'b1) begin
                for (int k = 0; k < 50 && o_tx_start !== 1'b1; k++) @(negedge clk);
                if (o_tx_start !== 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL start_timeout: byte %0d got no start within 50 cycles", b);
                    return;
                end
            end
            cur = o_tx_data;
            got = {got[55:0], cur};
            check("busy_in_send", 64'(o_busy), 64'd1);
            if (b == abort_at) begin
                @(negedge clk);
                return;
            end
            if (stray_send) i_tx_done = 1'b1;
            for (int j = 0; j < gap; j++) begin
                @(negedge clk);
                i_tx_done = 1'b0;
                if (mutate && b == 2 && j == 0) begin
                    i_halt = 1'b0;
                    i_acc  = 16'hBEEF;
                end
                if (mutate && b == 2 && j == 1) i_halt = 1'b1;
                check("start_width", 64'(o_tx_start), 64'd0);
                check("data_hold", 64'(o_tx_data), 64'(cur));
            end
            i_tx_done = 1'b1;
            @(negedge clk);
            i_tx_done = 1'b0;
        end
        check("done_pulse", 64'(o_done), 64'd1);
        check("busy_clear", 64'(o_busy), 64'd0);
        @(negedge clk);
        check("done_width", 64'(o_done), 64'd0);
    endtask

    // Send one complete frame and check its bytes and pulse counts.
    task automatic frame_txn(input string name, input logic [15:0] acc, input logic [10:0] pc,
                             input logic [15:0] cyc, input logic [63:0] exp,
                             input int gap, input bit stray_send, input bit mutate);
        logic [63:0] got;
        int s0, d0;
        i_acc = acc; i_pc = pc; i_cycles = cyc;
        s0 = start_cnt; d0 = done_cnt;
        raise_halt();
        serve_frame(gap, stray_send, mutate, 8, got);
        check({name, "_bytes"}, got, exp);
        check({name, "_starts"}, 64'(start_cnt - s0), 64'd8);
        check({name, "_dones"}, 64'(done_cnt - d0), 64'd1);
        $display("txn %s acc=%h pc=%h cyc=%h gap=%0d frame=%h", name, acc, pc, cyc, gap, got);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [63:0] got;
        logic [15:0] ra, rc;
        logic [10:0] rp;
        int gap;

        checks = 0; errors = 0;
        i_reset = 1'b1; i_halt = 1'b0; i_acc = '0; i_pc = '0; i_cycles = '0; i_tx_done = 1'b0;

        vecs[0] = '{acc: 16'h1234, pc: 11'h005, cyc: 16'h0010, exp: 64'hA5_00_05_12_34_00_10_33};
        vecs[1] = '{acc: 16'hFFFF, pc: 11'h7FF, cyc: 16'hFFFF, exp: 64'hA5_07_FF_FF_FF_FF_FF_F8};
        vecs[2] = '{acc: 16'h0000, pc: 11'h000, cyc: 16'h0000, exp: 64'hA5_00_00_00_00_00_00_00};
        vecs[3] = '{acc: 16'hABCD, pc: 11'h123, cyc: 16'h5678, exp: 64'hA5_01_23_AB_CD_56_78_6A};

        // Reset only.
        repeat (3) @(negedge clk);
        check("reset_outputs", {56'd0, o_tx_data}, 64'd0);
        check("reset_ctl", 64'({o_tx_start, o_busy, o_done}), 64'd0);
        i_reset = 1'b0;
        s0 = start_cnt;
        repeat (100) @(negedge clk);
        check("idle_no_start", 64'(start_cnt - s0), 64'd0);
        check("idle_ctl", 64'({o_tx_start, o_busy, o_done, o_tx_data}), 64'd0);
        $display("txn reset_idle starts=%0d", start_cnt - s0);

        // Table-driven frames; the first one uses a 10-cycle UART.
        for (int i = 0; i < 4; i++)
            frame_txn($sformatf("vec%0d", i), vecs[i].acc, vecs[i].pc, vecs[i].cyc,
                      vecs[i].exp, (i == 0) ? 9 : i + 1, 1'b0, 1'b0);

        // Holding halt high after a frame must not start another frame.
        s0 = start_cnt;
        repeat (500) @(negedge clk);
        check("hold_no_retrigger", 64'(start_cnt - s0), 64'd0);
        check("hold_idle_busy", 64'(o_busy), 64'd0);
        $display("txn halt_hold starts=%0d", start_cnt - s0);
        i_acc = 16'hFFFF; i_pc = 11'h005; i_cycles = 16'h0010;
        raise_halt();
        serve_frame(2, 1'b0, 1'b0, 8, got);
        check("retrigger_frame", got, ref_frame(16'hFFFF, 11'h005, 16'h0010));
        check("retrigger_acc_bytes", 64'(got[39:24]), 64'h0000_0000_0000_FFFF);
        $display("txn retrigger frame=%h", got);

        // Input change mid-frame and a halt pulse while busy.
        frame_txn("mutate", 16'h1234, 11'h005, 16'h0010, 64'hA5_00_05_12_34_00_10_33,
                  5, 1'b0, 1'b1);
        s0 = start_cnt;
        repeat (50) @(negedge clk);
        check("busy_trig_not_queued", 64'(start_cnt - s0), 64'd0);

        // Stray done pulses in IDLE, then in every SEND cycle.
        i_halt = 1'b0;
        s0 = start_cnt;
        repeat (3) begin
            i_tx_done = 1'b1; @(negedge clk);
            i_tx_done = 1'b0; @(negedge clk);
        end
        check("stray_idle_no_start", 64'(start_cnt - s0), 64'd0);
        frame_txn("stray", vecs[3].acc, vecs[3].pc, vecs[3].cyc, vecs[3].exp, 2, 1'b1, 1'b0);

        // Randomized frames against the reference model.
        for (int n = 0; n < 16; n++) begin
            ra  = 16'($urandom);
            rp  = 11'($urandom);
            rc  = 16'($urandom);
            gap = int'($urandom_range(1, 4));
            frame_txn($sformatf("rand%0d", n), ra, rp, rc, ref_frame(ra, rp, rc),
                      gap, n[0], 1'b0);
        end

        // Asynchronous reset in WAIT at idx 4.
        i_acc = 16'h1234; i_pc = 11'h005; i_cycles = 16'h0010;
        raise_halt();
        serve_frame(2, 1'b0, 1'b0, 4, got);
        check("abort_pre_busy", 64'(o_busy), 64'd1);
        check("abort_pre_data", 64'(o_tx_data), 64'h34);
        #2;
        i_reset = 1'b1;
        #1;
        check("abort_async_ctl", 64'({o_tx_start, o_busy, o_done}), 64'd0);
        check("abort_async_data", 64'(o_tx_data), 64'd0);
        i_halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        s0 = start_cnt;
        repeat (50) @(negedge clk);
        check("abort_no_resume", 64'(start_cnt - s0), 64'd0);
        check("abort_idle_ctl", 64'({o_tx_start, o_busy, o_done, o_tx_data}), 64'd0);
        $display("txn abort partial=%h starts_after=%0d", got, start_cnt - s0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
